// File: rtl/seq_divider_if.sv
// Operand/result bundle for the sequential divider: start/busy/done handshake plus data.
interface seq_divider_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;

    modport master (output start, x, y, input busy, done, q, r, dbz);
    modport slave  (input start, x, y, output busy, done, q, r, dbz);
endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock, start/busy/done handshake.
//   state  | meaning
//   S_IDLE | waiting for start; results from the last operation held
//   S_RUN  | one restoring step per edge, counter counts down to 0
//   S_DONE | single-cycle done pulse; a start here is accepted
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem, dvd, dvs;
    logic [WIDTH-1:0] q_r, r_r;
    logic             dbz_r;

    logic             accept, y_zero, neg;
    logic [WIDTH:0]   sh, trial;
    logic [WIDTH-1:0] rem_nxt, dvd_nxt;

    assign y_zero = (bus.y == '0);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            S_RUN: begin
                if (cnt == '0) state_nxt = S_DONE;
            end
            default: begin
                accept = bus.start;
                if (bus.start) state_nxt = y_zero ? S_DONE : S_RUN;
                else           state_nxt = S_IDLE;
            end
        endcase
    end

    // The partial remainder is always below the divisor, so bit WIDTH of
    // the trial difference is a reliable borrow flag.
    always_comb begin
        sh      = {rem, dvd[WIDTH-1]};
        trial   = sh - {1'b0, dvs};
        neg     = trial[WIDTH];
        rem_nxt = neg ? sh[WIDTH-1:0] : trial[WIDTH-1:0];
        dvd_nxt = {dvd[WIDTH-2:0], ~neg};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            rem   <= '0;
            dvd   <= '0;
            dvs   <= '0;
            q_r   <= '0;
            r_r   <= '0;
            dbz_r <= 1'b0;
        end else if (accept) begin
            if (y_zero) begin
                q_r   <= '1;
                r_r   <= bus.x;
                dbz_r <= 1'b1;
            end else begin
                dvd <= bus.x;
                dvs <= bus.y;
                rem <= '0;
                cnt <= CW'(WIDTH - 1);
            end
        end else if (state == S_RUN) begin
            rem <= rem_nxt;
            dvd <= dvd_nxt;
            cnt <= cnt - CW'(1);
            if (cnt == '0) begin
                q_r   <= dvd_nxt;
                r_r   <= rem_nxt;
                dbz_r <= 1'b0;
            end
        end
    end

    assign bus.busy = (state == S_RUN);
    assign bus.done = (state == S_DONE);
    assign bus.q    = q_r;
    assign bus.r    = r_r;
    assign bus.dbz  = dbz_r;
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential unsigned restoring divider; the inverse of the team's combinational multiplier (X*Y -> Z2).
- Computes the quotient and remainder of the dividend `x` divided by the divisor `y`.
- Produces one quotient bit per clock and uses a start/busy/done handshake.
- Instantiated inside the TinyTapeout top wrapper alongside the multiplier; operands come from `ui_in`/`uio_in` and results drive `uo_out`.

Parameters:
- WIDTH, 8, bit width of dividend, divisor, quotient and remainder (legal range 2..16).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request a division; sampled only when `busy`=0.
- x  input  WIDTH  dividend (unsigned); sampled at the accepting edge only.
- y  input  WIDTH  divisor (unsigned); sampled at the accepting edge only.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse; `q`/`r`/`dbz` are valid from this cycle.
- q  output  WIDTH  quotient.
- r  output  WIDTH  remainder.
- dbz  output  1  divide-by-zero flag for the last completed operation.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; `busy`, `done`, `dbz`=0; `q`, `r`=0; internal counter and shift registers=0.
  - Reset has priority over everything, including mid-operation; an aborted division never asserts `done`.
- States: IDLE, RUN, DONE.
- IDLE:
  - `busy`=0.
  - On an edge with start=1 and y!=0: latch x and y; clear partial remainder; counter=WIDTH-1; go to RUN; `busy`=1 next cycle.
  - On an edge with start=1 and y==0: go to DONE. Next cycle: `q`=all ones, `r`=x, `dbz`=1, `done`=1. `busy` stays 0.
- RUN:
  - One restoring step per edge: shift {rem, dividend} left 1; trial = rem - divisor, computed WIDTH+1 bits wide.
  - If trial is non-negative, rem=trial and the quotient LSB=1; otherwise the quotient LSB=0.
  - Counter decrements each step.
  - On the step with counter==0, register the final `q`/`r`, set `dbz`=0, and go to DONE.
  - `start` is ignored throughout RUN.
- DONE (one cycle): `done`=1, `busy`=0. Next edge returns to IDLE, with the same start-acceptance rules as IDLE.
  - A start presented in the DONE cycle is therefore accepted (back-to-back operation).
- Latency:
  - Start accepted at edge E0; `busy`=1 from E0 through E(WIDTH).
  - `done`=1 in the cycle after E(WIDTH), i.e. WIDTH+1 cycles after the start edge. `busy` falls in that same cycle.
  - Divide-by-zero: `done` in the cycle after E0.
- `q`, `r` and `dbz` hold their values from DONE until the next completed operation; they are not cleared by a new start.
- Arithmetic guarantee: x == q*y + r and r < y for all y!=0.
  - Edge cases: x=0 gives q=0, r=0; x<y gives q=0, r=x.
- `done` and `busy` are never high in the same cycle.

Test Plan (WIDTH=8):
- x=200, y=7, start pulsed 1 cycle -> `busy` high 8 cycles, then `done` pulse with q=28, r=4, dbz=0; `done` exactly 9 cycles after the start edge.
- Sweep of edge values:
  - x=255, y=1 -> q=255, r=0.
  - x=5, y=9 -> q=0, r=5.
  - x=0, y=3 -> q=0, r=0.
  - x=255, y=255 -> q=1, r=0.
- x=100, y=0 -> `done` the cycle after the start edge, `busy` never high, q=255, r=100, dbz=1. A following x=9, y=3 clears dbz to 0 with q=3.
- Start held high and operands changed (x=50, y=5 then x=99, y=2) during RUN -> result q=10, r=0. The held start is re-accepted in the DONE cycle, and the second result is q=49, r=1.
- rst=1 at the 4th RUN cycle of x=200, y=7 -> next cycle all outputs 0, no `done` pulse. A new start of x=17, y=4 then yields q=4, r=1.
- Random regression: 1000 random x/y (y!=0) checked against x/y and x%y, with `done` latency of 9 cycles on every operation.
